// File: rtl/puf_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : puf_uart_pkg
//  Description : Shared types and derived-constant helpers for the PUF
//                response UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package puf_uart_pkg;

  // Bit-engine states: idle line, start bit, eight data bits, stop bit.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Clock cycles per serial bit (integer division, truncating).
  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Number of bytes needed to carry a word of sz_in bits.
  function automatic int calc_nbytes(input int sz_in);
    return (sz_in + 7) / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_byte
//  Description : 8N1 bit engine. Accepts a byte on i_go (from idle, or in the
//                last stop-bit cycle so consecutive bytes have no gap) and
//                flags o_byte_done during the final cycle of the stop bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_byte,
  input  logic       i_go,
  output logic       o_tx,
  output logic       o_byte_done
);
  import puf_uart_pkg::*;

  localparam int              CW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   C_BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     r_state, w_state_nxt;
  logic [CW-1:0] r_baud,  w_baud_nxt;
  logic [2:0]    r_bit,   w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_tx,    w_tx_nxt;
  logic          w_baud_end;

  assign w_baud_end  = (r_baud == C_BAUD_LAST);
  assign o_byte_done = (r_state == ST_STOP) && w_baud_end;
  assign o_tx        = r_tx;

  // State and datapath registers; reset forces an idle-high line at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Next-state logic; the baud counter restarts at every bit boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
        if (i_go) begin
          w_state_nxt = ST_START;
          w_tx_nxt    = 1'b0;
          w_baud_nxt  = '0;
          w_shift_nxt = i_byte;
        end
      end
      ST_START: begin
        if (w_baud_end) begin
          w_state_nxt = ST_DATA;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      ST_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = ST_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 1'b1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      ST_STOP: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (i_go) begin
            w_state_nxt = ST_START;
            w_tx_nxt    = 1'b0;
            w_shift_nxt = i_byte;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/puf_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : puf_uart_tx
//  Description : Latches a PUF response word on i_load and streams it out as
//                UART 8N1 bytes, most-significant byte first, back to back.
//  Revision    : 1.0 - initial release
// ============================================================================
module puf_uart_tx #(
  parameter int SZ_IN       = 127,
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD        = 115200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SZ_IN-1:0] i_data,
  input  logic             i_load,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overrun
);
  import puf_uart_pkg::*;

  localparam int             CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int             NBYTES       = calc_nbytes(SZ_IN);
  localparam int             WW           = NBYTES * 8;
  localparam int             BCW          = $clog2(NBYTES + 1);
  localparam logic [BCW-1:0] C_LAST_BYTE  = BCW'(NBYTES - 1);

  logic [WW-1:0]  r_word;
  logic [BCW-1:0] r_byte_cnt;
  logic           r_busy;
  logic           r_done;
  logic           r_overrun;

  logic [WW-1:0]  w_ext;
  logic [7:0]     w_next_byte;
  logic [7:0]     w_byte;
  logic           w_accept;
  logic           w_chain;
  logic           w_finish;
  logic           w_go;
  logic           w_byte_done;

  // Zero-extend the response word to a whole number of bytes.
  always_comb begin
    w_ext              = '0;
    w_ext[SZ_IN-1:0]   = i_data;
  end

  // Byte following the one at the top of the in-flight shift register.
  generate
    if (NBYTES > 1) begin : g_next_byte
      assign w_next_byte = r_word[WW-9 -: 8];
    end else begin : g_single_byte
      assign w_next_byte = 8'h00;
    end
  endgenerate

  assign w_accept = i_load & ~r_busy;
  assign w_chain  = w_byte_done & r_busy & (r_byte_cnt != C_LAST_BYTE);
  assign w_finish = w_byte_done & r_busy & (r_byte_cnt == C_LAST_BYTE);
  assign w_go     = w_accept | w_chain;
  // An accepted load feeds byte 0 straight from the input so tx drops next cycle.
  assign w_byte   = r_busy ? w_next_byte : w_ext[WW-1 -: 8];

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_byte      (w_byte),
    .i_go        (w_go),
    .o_tx        (o_tx),
    .o_byte_done (w_byte_done)
  );

  // Word sequencing: latch on accept, advance one byte per finished frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word     <= '0;
      r_byte_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_done    <= w_finish;
      r_overrun <= i_load & r_busy;
      if (w_accept) begin
        r_word     <= w_ext;
        r_byte_cnt <= '0;
        r_busy     <= 1'b1;
      end else if (w_chain) begin
        r_word     <= r_word << 8;
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end else if (w_finish) begin
        r_byte_cnt <= '0;
        r_busy     <= 1'b0;
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_puf_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_puf_uart_tx
//  Description : Directed self-checking bench for puf_uart_tx with
//                SZ_IN=127, CLK_FREQ_HZ=400, BAUD=100 (4 clocks per bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_puf_uart_tx;

  localparam int LOGN = 1400;

  logic         clk;
  logic         rst_n;
  logic [126:0] i_data;
  logic         i_load;
  logic         o_tx;
  logic         o_busy;
  logic         o_done;
  logic         o_overrun;

  int n_cmp;
  int n_bad;
  int cyc;

  logic lg_tx   [0:LOGN-1];
  logic lg_busy [0:LOGN-1];
  logic lg_done [0:LOGN-1];
  logic lg_ovr  [0:LOGN-1];

  logic [127:0] w1_ext;
  logic [127:0] w2_ext;
  logic [127:0] ones_ext;

  puf_uart_tx #(
    .SZ_IN       (127),
    .CLK_FREQ_HZ (400),
    .BAUD        (100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_data    (i_data),
    .i_load    (i_load),
    .o_tx      (o_tx),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_overrun (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int c, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, c, obs, exp);
    end
  endtask

  // Advance one cycle, sample 1 time unit after the edge, log outputs.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= 0 && cyc < LOGN) begin
      lg_tx[cyc]   = o_tx;
      lg_busy[cyc] = o_busy;
      lg_done[cyc] = o_done;
      lg_ovr[cyc]  = o_overrun;
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  // Decode 16 frames starting at cycle s by mid-bit sampling.
  task automatic chk_word(input string tag, input int s, input logic [127:0] exp);
    logic [7:0] b;
    int base;
    for (int k = 0; k < 16; k++) begin
      base = s + k * 40;
      chk({tag, "_start"}, base + 2, {7'd0, lg_tx[base + 2]}, 8'h00);
      for (int i = 0; i < 8; i++) b[i] = lg_tx[base + 4 * (i + 1) + 2];
      chk({tag, "_stop"}, base + 38, {7'd0, lg_tx[base + 38]}, 8'h01);
      chk({tag, "_byte"}, base, b, exp[(15 - k) * 8 +: 8]);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    cyc      = 0;
    w1_ext   = 128'h7F00_0000_0000_0000_0000_0000_0000_00A5;
    w2_ext   = 128'h2B11_2233_4455_6677_8899_AABB_CCDD_EEFF;
    ones_ext = {1'b0, {127{1'b1}}};
    rst_n    = 1'b0;
    i_load   = 1'b0;
    i_data   = '0;

    // ---- Reset held for 3 cycles, then 50 quiet cycles ----
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx",   0, {7'd0, o_tx},      8'h01);
    chk("rst_busy", 0, {7'd0, o_busy},    8'h00);
    chk("rst_done", 0, {7'd0, o_done},    8'h00);
    chk("rst_ovr",  0, {7'd0, o_overrun}, 8'h00);
    rst_n = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk);
      #1;
      chk("idle_tx",   i, {7'd0, o_tx},      8'h01);
      chk("idle_busy", i, {7'd0, o_busy},    8'h00);
      chk("idle_done", i, {7'd0, o_done},    8'h00);
      chk("idle_ovr",  i, {7'd0, o_overrun}, 8'h00);
    end

    // ---- Framing, timing, overrun and back-to-back load ----
    cyc    = 0;
    i_data = w1_ext[126:0];
    i_load = 1'b1;
    step();
    i_load = 1'b0;
    i_data = '0;
    run_to(100);
    i_data = ones_ext[126:0];
    i_load = 1'b1;
    step();
    i_load = 1'b0;
    i_data = '0;
    run_to(641);
    i_data = w2_ext[126:0];
    i_load = 1'b1;
    step();
    i_load = 1'b0;
    i_data = ones_ext[126:0];
    run_to(1290);

    for (int c = 1; c <= 4; c++)      chk("start_low", c, {7'd0, lg_tx[c]}, 8'h00);
    for (int c = 637; c <= 641; c++)  chk("tail_high", c, {7'd0, lg_tx[c]}, 8'h01);
    for (int c = 642; c <= 645; c++)  chk("b2b_start", c, {7'd0, lg_tx[c]}, 8'h00);
    for (int c = 1283; c <= 1290; c++) chk("end_idle", c, {7'd0, lg_tx[c]}, 8'h01);
    for (int c = 1; c <= 1290; c++) begin
      chk("busy", c, {7'd0, lg_busy[c]},
          {7'd0, ((c >= 1 && c <= 640) || (c >= 642 && c <= 1281))});
      chk("done", c, {7'd0, lg_done[c]}, {7'd0, (c == 641 || c == 1282)});
      chk("overrun", c, {7'd0, lg_ovr[c]}, {7'd0, (c == 101)});
    end
    chk_word("w1", 1, w1_ext);
    chk_word("w2", 642, w2_ext);

    // ---- Reset in the middle of a frame, then a fresh word ----
    cyc    = 0;
    i_data = w1_ext[126:0];
    i_load = 1'b1;
    step();
    i_load = 1'b0;
    run_to(200);
    chk("pre_rst_busy", 200, {7'd0, o_busy}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx",   200, {7'd0, o_tx},   8'h01);
    chk("mid_rst_busy", 200, {7'd0, o_busy}, 8'h00);
    chk("mid_rst_done", 200, {7'd0, o_done}, 8'h00);
    run_to(202);
    rst_n = 1'b1;
    run_to(210);
    i_data = w2_ext[126:0];
    i_load = 1'b1;
    step();
    i_load = 1'b0;
    i_data = '0;
    run_to(860);

    for (int c = 201; c <= 210; c++) begin
      chk("rst_gap_busy", c, {7'd0, lg_busy[c]}, 8'h00);
      chk("rst_gap_tx",   c, {7'd0, lg_tx[c]},   8'h01);
    end
    for (int c = 201; c <= 860; c++) begin
      chk("re_done", c, {7'd0, lg_done[c]}, {7'd0, (c == 851)});
      chk("re_busy", c, {7'd0, lg_busy[c]}, {7'd0, (c >= 211 && c <= 850)});
    end
    chk_word("w2_restart", 211, w2_ext);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
